// File: rtl/inst_fetch_queue_pkg.sv
// ============================================================================
// Module  : inst_fetch_queue_pkg
// Purpose : Shared definitions for the instruction fetch queue slice.
//           Holds the bus widths, the zero word, the stall encodings, the
//           reset-active level and the default queue depth.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_queue_pkg;

  localparam int          INST_ADDR_W = 32;     // InstAddrBus width
  localparam int          INST_W      = 32;     // InstBus width
  localparam logic [31:0] ZERO_WORD   = 32'h0;  // also the nop encoding
  localparam logic        STOP        = 1'b1;   // stall level that holds a stage
  localparam logic        NO_STOP     = 1'b0;
  localparam logic        RST_ENABLE  = 1'b0;   // reset is active-low
  localparam int          IFQ_DEPTH   = 4;      // default queue depth

  // A power-of-two depth needs log2(DEPTH) pointer bits; never fewer than one.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_ifq_storage.sv
// ============================================================================
// Module  : ifq_storage
// Purpose : DEPTH x WIDTH register array for the instruction fetch queue.
//           One synchronous write port, one asynchronous read port.
//           Contents are deliberately not reset; validity is tracked by the
//           pointer/count logic in the parent.
// Ports   : clk      - clock, rising edge
//           wr_en    - write enable
//           wr_addr  - write index
//           wr_data  - write data
//           rd_addr  - read index
//           rd_data  - combinational read data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_storage #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module  : inst_fetch_queue
// Purpose : In-order {pc, inst} queue between the fetch stage and decode.
//           Absorbs decode stalls and discards everything on a flush.
// Ports   : clk, rst (async, active-low)
//           flush_i                          - discard all entries
//           fetch_valid_i/fetch_pc_i/fetch_inst_i, fetch_ready_o - fetch side
//           id_stall_i, id_valid_o/id_pc_o/id_inst_o             - decode side
//           count_o                          - occupancy 0..DEPTH
// Config  : IFQ_BYPASS_EN - when defined, an offer into an empty queue with
//           decode not stalled is forwarded combinationally to decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [ADDR_W-1:0]        fetch_pc_i,
  input  logic [DATA_W-1:0]        fetch_inst_i,
  output logic                     fetch_ready_o,
  input  logic                     id_stall_i,
  output logic                     id_valid_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [DATA_W-1:0]        id_inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  head_pc;
  logic [DATA_W-1:0]  head_inst;
  logic               empty;
  logic               full;
  logic               stalled;
  logic               push;
  logic               pop;
  logic               wr_en;   // push that actually lands in storage
  logic               rd_en;   // pop that actually retires a stored entry

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign stalled = (id_stall_i == STOP);
  assign {head_pc, head_inst} = head;

  // Ready looks only at the registered count, so a full queue refuses an
  // offer even when decode is draining in the same cycle.
  assign fetch_ready_o = ~full;
  assign push          = fetch_valid_i & fetch_ready_o;

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // Empty queue, decode free and no flush: hand the offer straight through.
  assign bypass     = empty & fetch_valid_i & ~stalled & ~flush_i;
  assign id_valid_o = ~empty | bypass;
  assign id_pc_o    = bypass ? fetch_pc_i   : (empty ? '0 : head_pc);
  assign id_inst_o  = bypass ? fetch_inst_i : (empty ? '0 : head_inst);
  assign wr_en      = push & ~bypass;
`else
  assign id_valid_o = ~empty;
  assign id_pc_o    = empty ? '0 : head_pc;
  assign id_inst_o  = empty ? '0 : head_inst;
  assign wr_en      = push;
`endif

  assign pop   = id_valid_o & ~stalled;
  // A bypassed entry is consumed without ever occupying a slot.
  assign rd_en = pop & ~empty;

  assign count_o = count;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      // Flush wins over push and pop; storage keeps stale data.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  ifq_storage #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en & ~flush_i),
    .wr_addr (wr_ptr),
    .wr_data ({fetch_pc_i, fetch_inst_i}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

endmodule

`default_nettype wire
